cpu_ex_md: RTL and testbench
============================

# cpu_ex_md

Parametrised execute-stage output latch with valid/ready handshaking and an integrated multi-cycle multiply/divide unit owning the HI/LO registers. It sits between ID/ALU and MEM. It stalls the upstream stage while a MULT/DIV is in flight and holds its output while MEM applies backpressure. Single-cycle operations pass the ALU result through with one cycle of latency.

## Interface
- XLEN, 32, datapath width for operands, result and HI/LO (≥ 8).
- MUL_LAT, 4, multiply latency in cycles spent in MUL state (≥ 1).
- clk  in  1  pipeline clock; all state updates on its rising edge.
- clr  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  block accepts this cycle; transfer when in_valid && in_ready.
- in_pc  in  XLEN  PC of the instruction.
- in_ins  in  32  raw instruction word.
- in_alu_result  in  XLEN  ALU result, passed through for md_op NONE.
- in_a  in  XLEN  operand A (rs).
- in_b  in  XLEN  operand B (rt).
- in_md_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 treated as NONE.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  MEM consumes the output this cycle.
- out_pc  out  XLEN  latched PC.
- out_ins  out  32  latched instruction.
- out_result  out  XLEN  latched result.
- hi, lo  out  XLEN each  architectural HI/LO.
- busy  out  1  high in MUL or DIV state.

## Operation
- States: IDLE, MUL, DIV.
- in_ready = !clr && state==IDLE && (!out_valid || out_ready). It is combinational.
- On accept in IDLE, by in_md_op:
  - NONE: out_result <= in_alu_result.
  - MFHI: out_result <= hi.
  - MFLO: out_result <= lo.
  - MTHI: hi <= in_a, out_result <= 0.
  - MTLO: lo <= in_a, out_result <= 0.
  - For all five: out_pc/out_ins latched, out_valid <= 1, state stays IDLE.
- On accept of MULT/MULTU/DIV/DIVU:
  - Operands, op, pc and ins are latched internally.
  - out_valid <= 0 (the previous entry was consumed in the same cycle or the register was already empty).
  - state -> MUL, or -> DIV with counter = XLEN.
- MUL: down-counter from MUL_LAT. Product is the full 2·XLEN result, signed (MULT) or unsigned (MULTU).
  - On the final cycle: {hi,lo} <= product; out register <= {pc, ins, result 0}; out_valid <= 1; -> IDLE.
- DIV: restoring division, one quotient bit per cycle, XLEN cycles. Signed ops divide magnitudes, then correct signs:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - On the final cycle: lo <= quotient, hi <= remainder, out register loaded with result 0, out_valid <= 1, -> IDLE.
- Special divide cases are resolved at the final cycle; iteration count is unchanged.
  - Divide by zero (DIV or DIVU): lo <= all ones, hi <= dividend.
  - Signed overflow (DIV, dividend = most negative, divisor = −1): lo <= dividend, hi <= 0.
- Output hold: while out_valid && !out_ready, all out_* stay stable and no new instruction is accepted.
- out_valid clears on out_ready unless a new entry loads in the same cycle.

## Timing
- Reset values, set on the first clk edge with clr high:
  - state IDLE, out_valid 0, out_pc 0, out_ins 0 (NOP), out_result 0, hi 0, lo 0, busy 0.
- clr takes priority over every other event. clr during MUL or DIV aborts the operation; hi/lo do not take the partial result.
- Single-cycle op accepted at edge N: out_valid high after edge N.
- MULT accepted at N: busy after N; out_valid and hi/lo updated after edge N+MUL_LAT.
- DIV accepted at N: out_valid and hi/lo updated after edge N+XLEN.
- An MFHI/MFLO following MULT/DIV reads the updated hi/lo. This holds by construction because in_ready stays low until completion.
- Simultaneous out_ready and accept in IDLE: the old entry leaves and the new entry loads in the same cycle, with no bubble.

## Test plan
- Pass-through: three back-to-back NONE ops with out_ready=1, in_alu_result 0x11/0x22/0x33 → out_result 0x11, 0x22, 0x33 on consecutive cycles; in_ready stays 1.
- MULT 0xFFFFFFFD × 5 → hi 0xFFFFFFFF, lo 0xFFFFFFF1 exactly MUL_LAT cycles after accept. MULTU with the same operands → hi 0x00000004, lo 0xFFFFFFF1. A following MFLO returns 0xFFFFFFF1.
- DIVU 100/7 → lo 14, hi 2, 32 cycles after accept. DIV −7/2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF.
- Divide corner cases:
  - DIV 0x80000000/0xFFFFFFFF → lo 0x80000000, hi 0.
  - DIVU 9/0 → lo 0xFFFFFFFF, hi 9.
  - in_ready is low throughout each operation.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_* stable and in_ready=0. Then raise out_ready with a new in_valid → handoff with no bubble.
- clr asserted mid-DIV (cycle 10) with hi=0x55 beforehand → next cycle IDLE, busy 0, out_valid 0, hi 0, lo 0; in_ready returns to 1 after clr falls.

Source files
------------

// File: rtl/cpu_ex_md.sv
// cpu_ex_md: execute-stage output latch with valid/ready handshaking and an
// integrated multi-cycle multiply/divide unit that owns the HI/LO registers.
//
// Ports:
//   clk, clr                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   in_pc, in_ins            instruction PC and raw word
//   in_alu_result            ALU result, passed through for non-MD ops
//   in_a, in_b, in_md_op     MD operands and operation select
//   out_valid / out_ready    downstream (MEM) handshake
//   out_pc, out_ins          latched PC / instruction
//   out_result               latched result
//   hi, lo                   architectural HI/LO
//   busy                     multiply or divide in flight
module cpu_ex_md #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_ins,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [3:0]      in_md_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_ins,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    localparam int unsigned CntMax = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e            state;
    logic [3:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, pc_q;
    logic [31:0]       ins_q;
    logic [CntW-1:0]   cnt;
    logic              a_neg_q, b_neg_q;
    logic [XLEN-1:0]   div_r, div_q, div_d;

    logic              accept, is_mult, is_div, in_signed, last;
    logic [XLEN-1:0]   a_mag_in, b_mag_in;
    logic [2*XLEN-1:0] prod_s, prod_u, prod;
    logic [XLEN:0]     r_shift;
    logic              ge;
    logic [XLEN-1:0]   r_next, q_next, quo, rem, div_lo, div_hi;

    assign in_ready  = !clr && (state == StIdle) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != StIdle);
    assign is_mult   = (in_md_op == OpMult) || (in_md_op == OpMultu);
    assign is_div    = (in_md_op == OpDiv) || (in_md_op == OpDivu);
    assign in_signed = (in_md_op == OpDiv);
    assign a_mag_in  = (in_signed && in_a[XLEN-1]) ? -in_a : in_a;
    assign b_mag_in  = (in_signed && in_b[XLEN-1]) ? -in_b : in_b;
    assign last      = (cnt == CntW'(1));

    // Sign-extending to 2*XLEN makes a plain multiply yield the signed product.
    assign prod_s = {{XLEN{a_q[XLEN-1]}}, a_q} * {{XLEN{b_q[XLEN-1]}}, b_q};
    assign prod_u = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
    assign prod   = (op_q == OpMult) ? prod_s : prod_u;

    // One restoring-division step; the remainder is always below the divisor,
    // so the low XLEN bits of the difference are exact.
    assign r_shift = {div_r, div_q[XLEN-1]};
    assign ge      = (r_shift >= {1'b0, div_d});
    assign r_next  = ge ? (r_shift[XLEN-1:0] - div_d) : r_shift[XLEN-1:0];
    assign q_next  = {div_q[XLEN-2:0], ge};
    assign quo     = (a_neg_q ^ b_neg_q) ? -q_next : q_next;
    assign rem     = a_neg_q ? -r_next : r_next;

    always_comb begin
        div_lo = quo;
        div_hi = rem;
        if (b_q == '0) begin
            div_lo = '1;
            div_hi = a_q;
        end else if ((op_q == OpDiv) && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1)) begin
            div_lo = a_q;
            div_hi = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= StIdle;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_ins    <= '0;
            out_result <= '0;
            hi         <= '0;
            lo         <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pc_q       <= '0;
            ins_q      <= '0;
            cnt        <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_r      <= '0;
            div_q      <= '0;
            div_d      <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        if (is_mult || is_div) begin
                            op_q      <= in_md_op;
                            a_q       <= in_a;
                            b_q       <= in_b;
                            pc_q      <= in_pc;
                            ins_q     <= in_ins;
                            a_neg_q   <= in_signed && in_a[XLEN-1];
                            b_neg_q   <= in_signed && in_b[XLEN-1];
                            div_r     <= '0;
                            div_q     <= a_mag_in;
                            div_d     <= b_mag_in;
                            out_valid <= 1'b0;
                            if (is_mult) begin
                                state <= StMul;
                                cnt   <= CntW'(MUL_LAT);
                            end else begin
                                state <= StDiv;
                                cnt   <= CntW'(XLEN);
                            end
                        end else begin
                            out_pc    <= in_pc;
                            out_ins   <= in_ins;
                            out_valid <= 1'b1;
                            case (in_md_op)
                                OpMfhi: out_result <= hi;
                                OpMflo: out_result <= lo;
                                OpMthi: begin
                                    hi         <= in_a;
                                    out_result <= '0;
                                end
                                OpMtlo: begin
                                    lo         <= in_a;
                                    out_result <= '0;
                                end
                                default: out_result <= in_alu_result;
                            endcase
                        end
                    end
                end
                StMul: begin
                    cnt <= cnt - CntW'(1);
                    if (last) begin
                        {hi, lo}   <= prod;
                        out_pc     <= pc_q;
                        out_ins    <= ins_q;
                        out_result <= '0;
                        out_valid  <= 1'b1;
                        state      <= StIdle;
                    end
                end
                StDiv: begin
                    cnt   <= cnt - CntW'(1);
                    div_r <= r_next;
                    div_q <= q_next;
                    if (last) begin
                        lo         <= div_lo;
                        hi         <= div_hi;
                        out_pc     <= pc_q;
                        out_ins    <= ins_q;
                        out_result <= '0;
                        out_valid  <= 1'b1;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ex_md.sv
// tb_cpu_ex_md: directed self-checking bench for cpu_ex_md with a scoreboard
// of expected output entries (pc, ins, result, hi, lo).
module tb_cpu_ex_md;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 4;

    localparam logic [3:0] OpNone  = 4'd0;
    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    logic            clk = 1'b0;
    logic            clr, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0]     in_pc, in_ins, in_alu_result, in_a, in_b;
    logic [3:0]      in_md_op;
    logic [31:0]     out_pc, out_ins, out_result, hi, lo;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi, m_lo, pc_ctr;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    cpu_ex_md #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk           (clk),
        .clr           (clr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_ins        (in_ins),
        .in_alu_result (in_alu_result),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_md_op      (in_md_op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_ins       (out_ins),
        .out_result    (out_result),
        .hi            (hi),
        .lo            (lo),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: returns the expected output entry, updates model HI/LO.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] alu,
                                   input logic [31:0] pc, input logic [31:0] ins);
        exp_t        e;
        logic [63:0] p;
        int          sa, sbv;
        e.pc  = pc;
        e.ins = ins;
        e.res = 32'h0;
        case (op)
            OpMult: begin
                p = 64'(longint'(signed'(a)) * longint'(signed'(b)));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OpMultu: begin
                p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OpDiv, OpDivu: begin
                if (b == 32'h0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (op == OpDiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a;
                    m_hi = 32'h0;
                end else if (op == OpDiv) begin
                    sa   = a;
                    sbv  = b;
                    m_lo = 32'(sa / sbv);
                    m_hi = 32'(sa % sbv);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            OpMfhi: e.res = m_hi;
            OpMflo: e.res = m_lo;
            OpMthi: m_hi = a;
            OpMtlo: m_lo = a;
            default: e.res = alu;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    // Called at a negedge after inputs are driven; advances to the next negedge.
    task automatic cyc();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_ins", out_ins, e.ins);
                chk("out_result", out_result, e.res);
                chk("out_hi", hi, e.hi);
                chk("out_lo", lo, e.lo);
            end
        end
        if (in_valid && in_ready)
            sb.push_back(model(in_md_op, in_a, in_b, in_alu_result, in_pc, in_ins));
        @(negedge clk);
    endtask

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] alu);
        in_valid      = 1'b1;
        in_md_op      = op;
        in_a          = a;
        in_b          = b;
        in_alu_result = alu;
        in_pc         = pc_ctr;
        in_ins        = 32'hA000_0000 | pc_ctr;
        pc_ctr        = pc_ctr + 32'd4;
    endtask

    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] alu);
        set_in(op, a, b, alu);
        #1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
    endtask

    // Counts edges from acceptance until out_valid rises; flags any stall leak.
    task automatic wait_done(input string tag, input int exp_lat);
        int k = 0;
        bit leak = 1'b0;
        while (!out_valid && k < 200) begin
            if (in_ready || !busy) leak = 1'b1;
            cyc();
            k++;
        end
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_stall"}, leak, 1'b0);
    endtask

    initial begin
        int k;
        logic [31:0] bp_pc;
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_ins = '0; in_alu_result = '0; in_a = '0; in_b = '0; in_md_op = '0;
        m_hi = '0; m_lo = '0; pc_ctr = 32'h1000;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_ins", out_ins, 32'h0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready_clr", in_ready, 1'b0);
        clr = 1'b0;
        #1;
        chk("rst_in_ready_after", in_ready, 1'b1);
        @(negedge clk);

        // Back-to-back pass-through, including an undefined op code
        issue("pt0", OpNone, 32'h0, 32'h0, 32'h11);
        issue("pt1", OpNone, 32'h0, 32'h0, 32'h22);
        chk("pt1_out", out_result, 32'h22);
        issue("pt2", OpNone, 32'h0, 32'h0, 32'h33);
        chk("pt2_out", out_result, 32'h33);
        issue("pt3", 4'd12, 32'h0, 32'h0, 32'h44);
        chk("pt3_out", out_result, 32'h44);
        cyc();

        // Multiply
        issue("mult", OpMult, 32'hFFFF_FFFD, 32'h5, 32'hDEAD);
        wait_done("mult", MUL_LAT);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        issue("multu", OpMultu, 32'hFFFF_FFFD, 32'h5, 32'hDEAD);
        wait_done("multu", MUL_LAT);
        chk("multu_hi", hi, 32'h0000_0004);
        chk("multu_lo", lo, 32'hFFFF_FFF1);
        issue("mflo", OpMflo, 32'h0, 32'h0, 32'hDEAD);
        chk("mflo_out", out_result, 32'hFFFF_FFF1);
        cyc();

        // Divide, including corner cases
        issue("divu", OpDivu, 32'd100, 32'd7, 32'hDEAD);
        wait_done("divu", XLEN);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        issue("div", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hDEAD);
        wait_done("div", XLEN);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        issue("mfhi", OpMfhi, 32'h0, 32'h0, 32'hDEAD);
        chk("mfhi_out", out_result, 32'hFFFF_FFFF);
        issue("divovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD);
        wait_done("divovf", XLEN);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0);
        issue("divz", OpDivu, 32'd9, 32'd0, 32'hDEAD);
        wait_done("divz", XLEN);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        chk("divz_hi", hi, 32'd9);
        issue("mtlo", OpMtlo, 32'h1234_5678, 32'h0, 32'hDEAD);
        chk("mtlo_lo", lo, 32'h1234_5678);
        cyc();

        // Backpressure hold, then handoff with no bubble
        out_ready = 1'b0;
        bp_pc = pc_ctr;
        issue("bp0", OpNone, 32'h0, 32'h0, 32'h77);
        set_in(OpNone, 32'h0, 32'h0, 32'h88);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_result", out_result, 32'h77);
            chk("bp_pc", out_pc, bp_pc);
            chk("bp_in_ready", in_ready, 1'b0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        #1;
        chk("bp_handoff_valid", out_valid, 1'b1);
        chk("bp_handoff_result", out_result, 32'h88);
        cyc();

        // Clear during a divide
        issue("mthi", OpMthi, 32'h55, 32'h0, 32'hDEAD);
        cyc();
        chk("mthi_hi", hi, 32'h55);
        issue("divabort", OpDivu, 32'd1000, 32'd3, 32'hDEAD);
        for (int i = 0; i < 9; i++) cyc();
        chk("abort_busy_before", busy, 1'b1);
        clr = 1'b1;
        cyc();
        chk("abort_busy", busy, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_in_ready_clr", in_ready, 1'b0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        clr  = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1'b1);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) k++;
            cyc();
        end
        chk("abort_no_completion", k, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
